sec_ded_dec_pipe: RTL and testbench

//  Pipelined SEC-DED decoder; consumes the 39-bit codewords produced by sec_ded_enc_top.

---
 rtl/sec_ded_dec_pipe.sv | 157 +++++++++++++++
 tb/tb_sec_ded_dec_pipe.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sec_ded_dec_pipe.sv
// Two-stage pipelined SEC-DED (39,32) decoder with valid/ready on both sides.
// Define DEC_ERR_CNT_EN to add saturating SBE/DBE counters with a sync clear.
module sec_ded_dec_pipe #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [38:0]      in_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [31:0]      out_o,
  output logic             sbe_o,
`ifdef DEC_ERR_CNT_EN
  output logic             dbe_o,
  input  logic             cnt_clr_i,
  output logic [CNT_W-1:0] sbe_cnt_o,
  output logic [CNT_W-1:0] dbe_cnt_o
`else
  output logic             dbe_o
`endif
);

  if (CNT_W == 0) begin : g_bad_cnt_w
    $error("CNT_W must be at least 1");
  end

  logic        s1_valid_q, s1_valid_d;
  logic [38:0] s1_cw_q, s1_cw_d;
  logic [5:0]  s1_syn_q, s1_syn_d;
  logic        s1_par_q, s1_par_d;

  logic        out_valid_q, out_valid_d;
  logic [31:0] out_q, out_d;
  logic        sbe_q, sbe_d;
  logic        dbe_q, dbe_d;

  logic        s2_advance, s1_advance, in_fire, out_fire;
  logic [5:0]  in_syn;
  logic [38:0] cw_fix;
  logic        syn_in_range;

  // Stage 2 frees up when empty or draining; stage 1 follows it.
  assign s2_advance = !out_valid_q || out_ready_i;
  assign s1_advance = s1_valid_q && s2_advance;
  assign in_ready_o = !s1_valid_q || s1_advance;
  assign in_fire    = in_valid_i && in_ready_o;
  assign out_fire   = out_valid_q && out_ready_i;

  always_comb begin
    in_syn = '0;
    for (logic [5:0] p = 6'd1; p <= 6'd38; p++) begin
      if (in_i[p - 6'd1]) in_syn ^= p;
    end
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_cw_d    = s1_cw_q;
    s1_syn_d   = s1_syn_q;
    s1_par_d   = s1_par_q;
    if (in_fire) begin
      s1_valid_d = 1'b1;
      s1_cw_d    = in_i;
      s1_syn_d   = in_syn;
      s1_par_d   = ^in_i;
    end else if (s1_advance) begin
      s1_valid_d = 1'b0;
    end
  end

  always_comb begin
    syn_in_range = (s1_syn_q != 6'd0) && (s1_syn_q <= 6'd38);
    cw_fix       = s1_cw_q;
    if (s1_par_q && syn_in_range) begin
      cw_fix[s1_syn_q - 6'd1] = ~s1_cw_q[s1_syn_q - 6'd1];
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_d       = out_q;
    sbe_d       = sbe_q;
    dbe_d       = dbe_q;
    if (s2_advance) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        // Data occupies every non-power-of-two Hamming position, D0 at position 3.
        out_d = {cw_fix[37:32], cw_fix[30:16], cw_fix[14:8], cw_fix[6:4], cw_fix[2]};
        sbe_d = s1_par_q && ((s1_syn_q == 6'd0) || syn_in_range);
        dbe_d = (!s1_par_q && (s1_syn_q != 6'd0)) || (s1_par_q && (s1_syn_q > 6'd38));
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid_q  <= 1'b0;
      s1_cw_q     <= '0;
      s1_syn_q    <= '0;
      s1_par_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      sbe_q       <= 1'b0;
      dbe_q       <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_cw_q     <= s1_cw_d;
      s1_syn_q    <= s1_syn_d;
      s1_par_q    <= s1_par_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      sbe_q       <= sbe_d;
      dbe_q       <= dbe_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_o       = out_q;
  assign sbe_o       = sbe_q;
  assign dbe_o       = dbe_q;

`ifdef DEC_ERR_CNT_EN
  logic [CNT_W-1:0] sbe_cnt_q, sbe_cnt_d;
  logic [CNT_W-1:0] dbe_cnt_q, dbe_cnt_d;

  always_comb begin
    sbe_cnt_d = sbe_cnt_q;
    dbe_cnt_d = dbe_cnt_q;
    if (cnt_clr_i) begin
      sbe_cnt_d = '0;
      dbe_cnt_d = '0;
    end else if (out_fire) begin
      if (sbe_q && (sbe_cnt_q != '1)) sbe_cnt_d = sbe_cnt_q + CNT_W'(1);
      if (dbe_q && (dbe_cnt_q != '1)) dbe_cnt_d = dbe_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sbe_cnt_q <= '0;
      dbe_cnt_q <= '0;
    end else begin
      sbe_cnt_q <= sbe_cnt_d;
      dbe_cnt_q <= dbe_cnt_d;
    end
  end

  assign sbe_cnt_o = sbe_cnt_q;
  assign dbe_cnt_o = dbe_cnt_q;
`else
  logic unused_out_fire;
  assign unused_out_fire = out_fire;
`endif

endmodule

// File: tb/tb_sec_ded_dec_pipe.sv
// Self-checking bench for sec_ded_dec_pipe: directed vectors, backpressure, counters
// (when DEC_ERR_CNT_EN is defined), randomized traffic against a scoreboard, and reset.
module tb_sec_ded_dec_pipe;

  localparam int unsigned CW     = 2;
  localparam int          CntMax = (1 << CW) - 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, sbe, dbe;
  logic [38:0] in_cw;
  logic [31:0] out_data;
`ifdef DEC_ERR_CNT_EN
  logic          cnt_clr;
  logic [CW-1:0] sbe_cnt, dbe_cnt;
`endif

  always #5 clk = ~clk;

  sec_ded_dec_pipe #(.CNT_W(CW)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_i       (in_cw),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_o      (out_data),
    .sbe_o      (sbe),
`ifdef DEC_ERR_CNT_EN
    .dbe_o      (dbe),
    .cnt_clr_i  (cnt_clr),
    .sbe_cnt_o  (sbe_cnt),
    .dbe_cnt_o  (dbe_cnt)
`else
    .dbe_o      (dbe)
`endif
  );

  typedef struct {
    logic [31:0] data;
    logic [38:0] flip;
    logic [31:0] exp_out;
    logic        exp_sbe;
    logic        exp_dbe;
  } vec_t;

  typedef struct {
    logic [31:0] d;
    logic        s;
    logic        e;
  } exp_t;

  vec_t vecs[8];
  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_sbe_cnt = 0;
  int   exp_dbe_cnt = 0;
  logic        held = 1'b0;
  logic [31:0] held_out;
  logic        held_sbe, held_dbe;

  // Reference encoder: data in non-power-of-two positions, check bits make syndrome zero.
  function automatic logic [38:0] enc(input logic [31:0] d);
    logic [38:0] cw;
    logic [5:0]  s;
    logic [4:0]  k;
    cw = '0;
    s  = '0;
    k  = '0;
    for (logic [5:0] p = 6'd1; p <= 6'd38; p++) begin
      if ((p & (p - 6'd1)) != 6'd0) begin
        cw[p - 6'd1] = d[k];
        if (d[k]) s ^= p;
        k++;
      end
    end
    cw[0]  = s[0];
    cw[1]  = s[1];
    cw[3]  = s[2];
    cw[7]  = s[3];
    cw[15] = s[4];
    cw[31] = s[5];
    cw[38] = ^cw[37:0];
    return cw;
  endfunction

  function automatic logic [31:0] extract(input logic [38:0] cw);
    logic [31:0] d;
    logic [4:0]  k;
    d = '0;
    k = '0;
    for (logic [5:0] p = 6'd1; p <= 6'd38; p++) begin
      if ((p & (p - 6'd1)) != 6'd0) begin
        d[k] = cw[p - 6'd1];
        k++;
      end
    end
    return d;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic count(input logic s, input logic e);
    if (s && exp_sbe_cnt < CntMax) exp_sbe_cnt++;
    if (e && exp_dbe_cnt < CntMax) exp_dbe_cnt++;
  endtask

  task automatic chk_cnt(input string nm);
`ifdef DEC_ERR_CNT_EN
    chk({nm, "_sbe_cnt"}, 64'(sbe_cnt), 64'(exp_sbe_cnt));
    chk({nm, "_dbe_cnt"}, 64'(dbe_cnt), 64'(exp_dbe_cnt));
`endif
  endtask

  // One randomized cycle; the scoreboard and in-flight count model the pipeline.
  task automatic rand_cycle(input bit allow_ready);
    logic [31:0] d;
    logic [38:0] mask;
    int          nflip, p1, p2;
    exp_t        e;
    @(negedge clk);
    d     = $urandom;
    nflip = $urandom_range(0, 2);
    p1    = $urandom_range(0, 38);
    p2    = (p1 + $urandom_range(1, 38)) % 39;
    mask  = '0;
    if (nflip >= 1) mask[p1] = 1'b1;
    if (nflip == 2) mask[p2] = 1'b1;
    in_valid  = ($urandom_range(0, 3) != 0);
    in_cw     = enc(d) ^ mask;
    out_ready = allow_ready ? ($urandom_range(0, 2) != 0) : 1'b0;
    #1;
    chk("rnd_in_ready", 64'(in_ready), 64'((q.size() < 2) || out_ready));
    if (held) begin
      chk("rnd_hold_valid", 64'(out_valid), 64'd1);
      chk("rnd_hold_out", 64'(out_data), 64'(held_out));
      chk("rnd_hold_flags", 64'({sbe, dbe}), 64'({held_sbe, held_dbe}));
    end
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rnd_extra_beat: got beat %0h expected none", out_data);
      end else begin
        e = q.pop_front();
        chk("rnd_out", 64'(out_data), 64'(e.d));
        chk("rnd_flags", 64'({sbe, dbe}), 64'({e.s, e.e}));
        count(e.s, e.e);
      end
    end
    if (in_valid && in_ready) begin
      e.d = (nflip == 2) ? extract(enc(d) ^ mask) : d;
      e.s = (nflip == 1);
      e.e = (nflip == 2);
      q.push_back(e);
    end
    checks++;
    if (q.size() > 2) begin
      errors++;
      $display("FAIL rnd_inflight: got %0d expected at most 2", q.size());
    end
    held     = out_valid && !out_ready;
    held_out = out_data;
    held_sbe = sbe;
    held_dbe = dbe;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{32'h0000_0000, 39'h0,                  32'h0000_0000, 1'b0, 1'b0};
    vecs[1] = '{32'hDEAD_BEEF, 39'h1 << 2,             32'hDEAD_BEEF, 1'b1, 1'b0};
    vecs[2] = '{32'hDEAD_BEEF, 39'h1 << 38,            32'hDEAD_BEEF, 1'b1, 1'b0};
    vecs[3] = '{32'hDEAD_BEEF, 39'h1,                  32'hDEAD_BEEF, 1'b1, 1'b0};
    vecs[4] = '{32'h1234_5678, (39'h1 << 2) | (39'h1 << 9), 32'h1234_5659, 1'b0, 1'b1};
    vecs[5] = '{32'hDEAD_BEEF, 39'h1 << 37,            32'hDEAD_BEEF, 1'b1, 1'b0};
    vecs[6] = '{32'hDEAD_BEEF, 39'h1 << 31,            32'hDEAD_BEEF, 1'b1, 1'b0};
    // Syndrome 39 with odd parity: out of range, reported as DBE and left uncorrected.
    vecs[7] = '{32'hDEAD_BEEF, (39'h1 << 31) | (39'h1 << 6) | (39'h1 << 38),
                32'hDEAD_BEE7, 1'b0, 1'b1};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_cw     = '0;
    out_ready = 1'b1;
`ifdef DEC_ERR_CNT_EN
    cnt_clr   = 1'b0;
`endif
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out", 64'(out_data), 64'd0);
    chk("rst_flags", 64'({sbe, dbe}), 64'd0);
    chk_cnt("rst");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_cw    = enc(vecs[i].data) ^ vecs[i].flip;
      #1;
      chk("vec_in_ready", 64'(in_ready), 64'd1);
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      chk("vec_latency", 64'(out_valid), 64'd0);
      @(negedge clk);
      #1;
      chk("vec_out_valid", 64'(out_valid), 64'd1);
      chk("vec_out", 64'(out_data), 64'(vecs[i].exp_out));
      chk("vec_sbe", 64'(sbe), 64'(vecs[i].exp_sbe));
      chk("vec_dbe", 64'(dbe), 64'(vecs[i].exp_dbe));
      count(vecs[i].exp_sbe, vecs[i].exp_dbe);
    end
    @(negedge clk);
    #1;
    chk_cnt("vec");

    // Backpressure: three clean beats queued behind a stalled consumer.
    out_ready = 1'b0;
    for (int i = 1; i <= 2; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_cw    = enc(32'(i));
      #1;
      chk("bp_accept", 64'(in_ready), 64'd1);
    end
    @(negedge clk);
    in_cw = enc(32'd3);
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      chk("bp_stall_ready", 64'(in_ready), 64'd0);
      chk("bp_hold_out", 64'({out_valid, out_data}), {31'd0, 1'b1, 32'd1});
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 64'(in_ready), 64'd1);
    chk("bp_out1", 64'({out_valid, out_data}), {31'd0, 1'b1, 32'd1});
    for (int i = 2; i <= 3; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      chk("bp_out_seq", 64'({out_valid, out_data}), {31'd0, 1'b1, 32'(i)});
    end
    @(negedge clk);
    #1;
    chk("bp_drained", 64'(out_valid), 64'd0);

`ifdef DEC_ERR_CNT_EN
    // Clear wins over an SBE transfer in the same cycle.
    @(negedge clk);
    in_valid = 1'b1;
    in_cw    = enc(32'hDEAD_BEEF) ^ (39'h1 << 2);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    cnt_clr = 1'b1;
    #1;
    chk("clr_sbe_beat", 64'({out_valid, sbe}), 64'b11);
    @(negedge clk);
    cnt_clr     = 1'b0;
    exp_sbe_cnt = 0;
    exp_dbe_cnt = 0;
    #1;
    chk_cnt("clr");
`endif

    for (int c = 0; c < 400; c++) rand_cycle(1'b1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 10 && q.size() > 0; c++) rand_cycle(1'b1);
    chk("rnd_drained", 64'(q.size()), 64'd0);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk_cnt("rnd");

    // Reset with beats in flight discards them immediately.
    for (int c = 0; c < 4; c++) rand_cycle(1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_out", 64'({out_data, sbe, dbe}), 64'd0);
    exp_sbe_cnt = 0;
    exp_dbe_cnt = 0;
    chk_cnt("midrst");
    q.delete();
    held = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    #1;
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    #1;
    chk("midrst_no_ghost", 64'(out_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
